// File: rtl/shift_reg_pkg.sv
// Shared mode encodings and small helpers for the multi-mode shift register
// and the blocks/benches built around it.
package shift_reg_pkg;

    localparam logic [2:0] SR_HOLD = 3'd0;
    localparam logic [2:0] SR_SHF  = 3'd1;
    localparam logic [2:0] SR_SHB  = 3'd2;
    localparam logic [2:0] SR_ROT  = 3'd3;
    localparam logic [2:0] SR_LOAD = 3'd4;
    localparam logic [2:0] SR_CLR  = 3'd5;

    // Serial shifts are the only modes that add one sample of occupancy.
    function automatic logic sr_is_shift(input logic [2:0] mode);
        return (mode == SR_SHF) || (mode == SR_SHB);
    endfunction

endpackage

// File: rtl/shift_reg_fill_ctr.sv
// Saturating 0..DEPTH occupancy counter; clear beats set_full beats inc.
module shift_reg_fill_ctr #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          inc,
    input  logic          set_full,
    input  logic          clear,
    output logic [CW-1:0] cnt,
    output logic          full
);

    logic [CW-1:0] r_cnt;
    logic          w_at_max;

    assign w_at_max = (r_cnt == CW'(DEPTH));

    // Occupancy register; an increment at DEPTH saturates rather than wrapping.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_cnt <= {CW{1'b0}};
        end else if (clear) begin
            r_cnt <= {CW{1'b0}};
        end else if (set_full) begin
            r_cnt <= CW'(DEPTH);
        end else if (inc && !w_at_max) begin
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign cnt  = r_cnt;
    assign full = w_at_max;

endmodule

// File: rtl/shift_reg_multi.sv
// DEPTH x WIDTH shift register with forward/backward shift, rotate, parallel
// load and clear, plus occupancy tracking and LSB edge flags.
module shift_reg_multi
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   en,
    input  logic [2:0]             mode,
    input  logic [WIDTH-1:0]       din,
    input  logic [DEPTH*WIDTH-1:0] load_data,
    output logic [WIDTH-1:0]       dout,
    output logic [DEPTH*WIDTH-1:0] taps,
    output logic [CW-1:0]          fill_cnt,
    output logic                   full,
    output logic                   rise,
    output logic                   fall
);

    logic [DEPTH*WIDTH-1:0] w_taps;
    logic                   w_inc;
    logic                   w_set_full;
    logic                   w_clear;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic [WIDTH-1:0] r_stg;
        logic [WIDTH-1:0] w_fwd_src;
        logic [WIDTH-1:0] w_rot_src;
        logic [WIDTH-1:0] w_bwd_src;

        if (g == 0) begin : g_head
            assign w_fwd_src = din;
            assign w_rot_src = w_taps[(DEPTH-1)*WIDTH +: WIDTH];
        end else begin : g_body
            assign w_fwd_src = w_taps[(g-1)*WIDTH +: WIDTH];
            assign w_rot_src = w_taps[(g-1)*WIDTH +: WIDTH];
        end

        if (g == DEPTH - 1) begin : g_tail
            assign w_bwd_src = din;
        end else begin : g_inner
            assign w_bwd_src = w_taps[(g+1)*WIDTH +: WIDTH];
        end

        // One stage of storage; reserved modes fall through to hold.
        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                r_stg <= {WIDTH{1'b0}};
            end else if (en) begin
                case (mode)
                    SR_SHF:  r_stg <= w_fwd_src;
                    SR_SHB:  r_stg <= w_bwd_src;
                    SR_ROT:  r_stg <= w_rot_src;
                    SR_LOAD: r_stg <= load_data[g*WIDTH +: WIDTH];
                    SR_CLR:  r_stg <= {WIDTH{1'b0}};
                    default: r_stg <= r_stg;
                endcase
            end else begin
                r_stg <= r_stg;
            end
        end

        assign w_taps[g*WIDTH +: WIDTH] = r_stg;
    end

    assign w_inc      = en && sr_is_shift(mode);
    assign w_set_full = en && (mode == SR_LOAD);
    assign w_clear    = en && (mode == SR_CLR);

    shift_reg_fill_ctr #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fill_ctr (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .inc      (w_inc),
        .set_full (w_set_full),
        .clear    (w_clear),
        .cnt      (fill_cnt),
        .full     (full)
    );

    assign taps = w_taps;
    assign dout = w_taps[(DEPTH-1)*WIDTH +: WIDTH];
    assign rise = w_taps[0] & ~w_taps[WIDTH];
    assign fall = ~w_taps[0] & w_taps[WIDTH];

endmodule

// File: tb/tb_shift_reg_multi.sv
// Self-checking bench for shift_reg_multi: directed scenarios plus a
// randomized run against an array-based reference model.
module tb_shift_reg_multi;
    import shift_reg_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                   sys_clk;
    logic                   sys_rst;
    logic                   en;
    logic [2:0]             mode;
    logic [WIDTH-1:0]       din;
    logic [DEPTH*WIDTH-1:0] load_data;
    logic [WIDTH-1:0]       dout;
    logic [DEPTH*WIDTH-1:0] taps;
    logic [CW-1:0]          fill_cnt;
    logic                   full;
    logic                   rise;
    logic                   fall;

    int n_checks;
    int n_fail;

    // Reference model: a plain array of words plus an integer occupancy.
    logic [WIDTH-1:0] m_stg [DEPTH];
    int               m_fill;

    shift_reg_multi #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .en        (en),
        .mode      (mode),
        .din       (din),
        .load_data (load_data),
        .dout      (dout),
        .taps      (taps),
        .fill_cnt  (fill_cnt),
        .full      (full),
        .rise      (rise),
        .fall      (fall)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [DEPTH*WIDTH-1:0] model_taps();
        logic [DEPTH*WIDTH-1:0] v;
        for (int i = 0; i < DEPTH; i++) v[i*WIDTH +: WIDTH] = m_stg[i];
        return v;
    endfunction

    task automatic model_step(input logic r, input logic e, input logic [2:0] m,
                              input logic [WIDTH-1:0] d, input logic [DEPTH*WIDTH-1:0] ld);
        logic [WIDTH-1:0] tmp;
        if (r) begin
            for (int i = 0; i < DEPTH; i++) m_stg[i] = '0;
            m_fill = 0;
        end else if (e) begin
            if (m == SR_SHF) begin
                for (int i = DEPTH - 1; i > 0; i--) m_stg[i] = m_stg[i-1];
                m_stg[0] = d;
                m_fill = (m_fill < DEPTH) ? m_fill + 1 : DEPTH;
            end else if (m == SR_SHB) begin
                for (int i = 0; i < DEPTH - 1; i++) m_stg[i] = m_stg[i+1];
                m_stg[DEPTH-1] = d;
                m_fill = (m_fill < DEPTH) ? m_fill + 1 : DEPTH;
            end else if (m == SR_ROT) begin
                tmp = m_stg[DEPTH-1];
                for (int i = DEPTH - 1; i > 0; i--) m_stg[i] = m_stg[i-1];
                m_stg[0] = tmp;
            end else if (m == SR_LOAD) begin
                for (int i = 0; i < DEPTH; i++) m_stg[i] = ld[i*WIDTH +: WIDTH];
                m_fill = DEPTH;
            end else if (m == SR_CLR) begin
                for (int i = 0; i < DEPTH; i++) m_stg[i] = '0;
                m_fill = 0;
            end
        end
    endtask

    // Apply one clock edge with the given inputs and advance the model.
    task automatic cycle(input logic r, input logic e, input logic [2:0] m,
                         input logic [WIDTH-1:0] d, input logic [DEPTH*WIDTH-1:0] ld);
        sys_rst = r; en = e; mode = m; din = d; load_data = ld;
        @(posedge sys_clk);
        #1;
        model_step(r, e, m, d, ld);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, SR_SHF, 8'hFF, '0);
        n_checks++;
        if (taps !== 32'h0 || dout !== 8'h00) begin
            n_fail++; $display("FAIL reset_data taps=%h dout=%h want 0", taps, dout);
        end
        n_checks++;
        if (fill_cnt !== 3'd0 || full !== 1'b0 || rise !== 1'b0 || fall !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags fill=%0d full=%b rise=%b fall=%b want 0", fill_cnt, full, rise, fall);
        end
    endtask

    task automatic test_fwd_fill();
        logic [WIDTH-1:0] seq [4];
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
        cycle(1'b0, 1'b1, SR_HOLD, 8'h00, '0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, SR_SHF, seq[i], '0);
            n_checks++;
            if (taps[7:0] !== seq[i] || fill_cnt !== CW'(i + 1)) begin
                n_fail++; $display("FAIL fwd_tap0 step=%0d tap0=%h fill=%0d want %h/%0d", i, taps[7:0], fill_cnt, seq[i], i + 1);
            end
        end
        n_checks++;
        if (dout !== 8'h11 || full !== 1'b1 || taps !== 32'h11223344) begin
            n_fail++; $display("FAIL fwd_full dout=%h full=%b taps=%h want 11/1/11223344", dout, full, taps);
        end
        cycle(1'b0, 1'b1, SR_SHF, 8'h55, '0);
        n_checks++;
        if (dout !== 8'h22 || fill_cnt !== 3'd4 || full !== 1'b1) begin
            n_fail++; $display("FAIL fwd_saturate dout=%h fill=%0d full=%b want 22/4/1", dout, fill_cnt, full);
        end
    endtask

    task automatic test_bwd_rot();
        cycle(1'b0, 1'b1, SR_CLR, 8'h00, '0);
        cycle(1'b0, 1'b1, SR_LOAD, 8'h00, 32'h44332211);
        n_checks++;
        if (taps !== 32'h44332211 || full !== 1'b1) begin
            n_fail++; $display("FAIL load taps=%h full=%b want 44332211/1", taps, full);
        end
        cycle(1'b0, 1'b1, SR_ROT, 8'h00, '0);
        n_checks++;
        if (taps !== 32'h33221144 || fill_cnt !== 3'd4) begin
            n_fail++; $display("FAIL rot taps=%h fill=%0d want 33221144/4", taps, fill_cnt);
        end
        cycle(1'b0, 1'b1, SR_SHB, 8'hAA, '0);
        n_checks++;
        if (taps !== 32'hAA332211 || dout !== 8'hAA) begin
            n_fail++; $display("FAIL shb taps=%h dout=%h want AA332211/AA", taps, dout);
        end
    endtask

    task automatic test_edge();
        logic [4:0] bits;
        logic       exp_rise;
        logic       exp_fall;
        bits = 5'b01100; // bit k is the LSB shifted on edge k+1: 0,0,1,1,0
        cycle(1'b0, 1'b1, SR_CLR, 8'h00, '0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b1, SR_SHF, {7'($urandom), bits[k]}, '0);
            exp_rise = (k == 2);
            exp_fall = (k == 4);
            n_checks++;
            if (rise !== exp_rise || fall !== exp_fall) begin
                n_fail++; $display("FAIL edge step=%0d rise=%b fall=%b want %b/%b", k + 1, rise, fall, exp_rise, exp_fall);
            end
        end
        cycle(1'b0, 1'b1, SR_HOLD, 8'h00, '0);
        n_checks++;
        if (fall !== 1'b1) begin
            n_fail++; $display("FAIL edge_hold fall=%b want 1", fall);
        end
    endtask

    task automatic test_hold();
        cycle(1'b0, 1'b1, SR_CLR, 8'h00, '0);
        cycle(1'b0, 1'b1, SR_SHF, 8'hA5, '0);
        cycle(1'b0, 1'b1, SR_SHF, 8'h5A, '0);
        cycle(1'b0, 1'b1, 3'd6, 8'hFF, 32'hFFFFFFFF);
        cycle(1'b0, 1'b1, 3'd7, 8'hFF, 32'hFFFFFFFF);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, SR_SHF, 8'($urandom), 32'($urandom));
            n_checks++;
            if (taps !== 32'h0000A55A || fill_cnt !== 3'd2) begin
                n_fail++; $display("FAIL hold step=%0d taps=%h fill=%0d want 0000A55A/2", i, taps, fill_cnt);
            end
        end
    endtask

    task automatic test_mid_reset_clear();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, SR_SHF, 8'(i + 8'h71), '0);
        cycle(1'b1, 1'b1, SR_SHF, 8'hEE, '0);
        n_checks++;
        if (taps !== 32'h0 || fill_cnt !== 3'd0 || full !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset taps=%h fill=%0d full=%b want 0", taps, fill_cnt, full);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, SR_SHF, 8'(i + 8'hC1), '0);
        n_checks++;
        if (taps !== 32'hC1C2C3C4 || full !== 1'b1) begin
            n_fail++; $display("FAIL refill taps=%h full=%b want C1C2C3C4/1", taps, full);
        end
        cycle(1'b0, 1'b1, SR_CLR, 8'hFF, '0);
        n_checks++;
        if (taps !== 32'h0 || fill_cnt !== 3'd0 || full !== 1'b0) begin
            n_fail++; $display("FAIL clear taps=%h fill=%0d full=%b want 0", taps, fill_cnt, full);
        end
    endtask

    task automatic test_random();
        logic [DEPTH*WIDTH-1:0] exp_taps;
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) != 0),
                  3'($urandom_range(0, 7)), 8'($urandom), 32'($urandom));
            exp_taps = model_taps();
            n_checks++;
            if (taps !== exp_taps || dout !== m_stg[DEPTH-1] || fill_cnt !== CW'(m_fill) ||
                full !== (m_fill == DEPTH) || rise !== (m_stg[0][0] & ~m_stg[1][0]) ||
                fall !== (~m_stg[0][0] & m_stg[1][0])) begin
                n_fail++;
                $display("FAIL random n=%0d taps=%h dout=%h fill=%0d full=%b rise=%b fall=%b want taps=%h fill=%0d",
                         n, taps, dout, fill_cnt, full, rise, fall, exp_taps, m_fill);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_fill   = 0;
        for (int i = 0; i < DEPTH; i++) m_stg[i] = '0;
        sys_rst = 1'b1; en = 1'b0; mode = SR_HOLD; din = '0; load_data = '0;
        test_reset();
        test_fwd_fill();
        test_bwd_rot();
        test_edge();
        test_hold();
        test_mid_reset_clear();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
